// File: rtl/sync_fifo_wr_arbiter_pkg.sv
// Shared types and constants for the sync_fifo write-port arbiter.
//   arb_state_t : FSM encoding (idle/arbitrate vs. burst-owning)
//   STALL_CNT_W : width of the saturating full-stall debug counter
package fifo_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
  localparam int STALL_CNT_W = 16;
endpackage

// File: rtl/sync_fifo_wr_arbiter_if.sv
// Producer-side request bus plus the sync_fifo write port.
//   req[i]        requester i has a word on req_data[i]
//   req_data[i]   word of requester i (flat bit layout = slice i*FIFO_WIDTH)
//   gnt[i]        one-hot: word of requester i consumed this cycle
//   fifo_full     from sync_fifo
//   fifo_write    to sync_fifo.write
//   fifo_data_in  to sync_fifo.data_in
// slave = arbiter view, master = producers + FIFO view.
interface sync_fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16
);
  logic [NUM_REQ-1:0]                 req;
  logic [NUM_REQ-1:0][FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 gnt;
  logic                               fifo_full;
  logic                               fifo_write;
  logic [FIFO_WIDTH-1:0]              fifo_data_in;

  modport slave  (input req, req_data, fifo_full, output gnt, fifo_write, fifo_data_in);
  modport master (output req, req_data, fifo_full, input gnt, fifo_write, fifo_data_in);
endinterface

// File: rtl/sync_fifo_wr_arbiter_rr_priority_pick.sv
// Combinational round-robin search: first requester at or after rr_ptr_i.
//   req_i     request vector
//   rr_ptr_i  search start index (< NUM_REQ)
//   pick_o    index of the first requester found (0 when none)
//   any_req_o at least one request present
module rr_priority_pick import fifo_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  localparam int PW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      rr_ptr_i,
  output logic [PW-1:0]      pick_o,
  output logic               any_req_o
);
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest hit is the last
  // assignment. The extra sum bit plus explicit subtract handles
  // non-power-of-2 NUM_REQ wrap.
  always_comb begin
    pick_o = '0;
    sum    = '0;
    idx    = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
      idx = sum[PW-1:0];
      if (req_i[idx]) pick_o = idx;
    end
  end

  assign any_req_o = |req_i;
endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port among NUM_REQ
// producers. A winner owns the port for up to MAX_BURST words; the FIFO is
// never written while full. One bubble cycle per arbitration.
//   clk, reset   clock; synchronous active-low reset
//   bus          request/grant + FIFO write port (slave modport)
//   owner_o      current grant owner (valid while busy_o)
//   busy_o       burst in progress
//   stall_cnt_o  saturating count of burst cycles blocked by fifo_full
module sync_fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  sync_fifo_wr_arbiter_if.slave        bus,
  output logic [$clog2(NUM_REQ)-1:0]   owner_o,
  output logic                         busy_o,
  output logic [STALL_CNT_W-1:0]       stall_cnt_o
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST+1);

  arb_state_t             state_q, state_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]          owner_q, owner_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic [PW-1:0]         pick;
  logic                  any_req;
  logic                  busy, owner_req, wr;
  logic [FIFO_WIDTH-1:0] data_sel;

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i     (bus.req),
    .rr_ptr_i  (rr_ptr_q),
    .pick_o    (pick),
    .any_req_o (any_req)
  );

  // Zero-latency write path; reset gates it so nothing is written while
  // reset is asserted, even mid-burst.
  assign busy      = (state_q == ARB_BURST);
  assign owner_req = bus.req[owner_q];
  assign wr        = reset && busy && owner_req && !bus.fifo_full;
  assign data_sel  = bus.req_data[owner_q];

  assign bus.fifo_write   = wr;
  assign bus.fifo_data_in = data_sel;

  always_comb begin
    bus.gnt = '0;
    if (wr) bus.gnt[owner_q] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    beat_d   = beat_q;
    stall_d  = stall_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          owner_d = pick;
          beat_d  = '0;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (wr) beat_d = beat_q + BW'(1);
        if (owner_req && bus.fifo_full && stall_q != '1)
          stall_d = stall_q + STALL_CNT_W'(1);
        // Dropping req ends the burst even before the first beat, and the
        // pointer still rotates past this owner.
        if ((wr && beat_q == BW'(MAX_BURST-1)) || !owner_req) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (owner_q == PW'(NUM_REQ-1)) ? '0 : owner_q + PW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      beat_q   <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      beat_q   <= beat_d;
      stall_q  <= stall_d;
    end
  end

  assign owner_o     = owner_q;
  assign busy_o      = busy;
  assign stall_cnt_o = stall_q;
endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
module tb_sync_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic tb_clr;
  logic pop;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // main DUT: NUM_REQ=4, FIFO_WIDTH=16, MAX_BURST=4
  sync_fifo_wr_arbiter_if #(.NUM_REQ(4), .FIFO_WIDTH(16)) bus ();
  logic [1:0]  owner;
  logic        busy;
  logic [15:0] stall;

  sync_fifo_wr_arbiter #(.NUM_REQ(4), .FIFO_WIDTH(16), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .owner_o(owner), .busy_o(busy), .stall_cnt_o(stall)
  );

  // second DUT: MAX_BURST=1, FIFO never full
  sync_fifo_wr_arbiter_if #(.NUM_REQ(4), .FIFO_WIDTH(16)) bus_b ();
  logic [1:0]  owner_b;
  logic        busy_b;
  logic [15:0] stall_b;

  sync_fifo_wr_arbiter #(.NUM_REQ(4), .FIFO_WIDTH(16), .MAX_BURST(1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b),
    .owner_o(owner_b), .busy_o(busy_b), .stall_cnt_o(stall_b)
  );

  assign bus_b.fifo_full = 1'b0;
  always_comb
    for (int i = 0; i < 4; i++) bus_b.req_data[i] = 16'(16'h1111 * i);

  // producers: word = {id, per-requester sequence number}
  logic [11:0] w [4];
  always_comb
    for (int i = 0; i < 4; i++) bus.req_data[i] = {4'(i), w[i]};

  // depth-32 FIFO model
  logic [15:0] q[$];
  int          cnt;
  assign bus.fifo_full = (cnt >= 32);

  always @(posedge clk) begin
    if (tb_clr) begin
      q.delete();
      for (int i = 0; i < 4; i++) w[i] <= '0;
    end else begin
      if (pop && q.size() > 0) void'(q.pop_front());
      if (bus.fifo_write) q.push_back(bus.fifo_data_in);
      for (int i = 0; i < 4; i++) if (bus.gnt[i]) w[i] <= w[i] + 12'd1;
    end
    cnt <= q.size();
  end

  task automatic do_reset();
    reset = 1'b0; tb_clr = 1'b1; pop = 1'b0;
    bus.req = '0; bus_b.req = '0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1; tb_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; tb_clr = 1'b1; pop = 1'b0;
    bus.req = 4'b1111; bus_b.req = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (bus.gnt !== 4'b0) begin bad++; $display("FAIL reset_gnt got=%h exp=0", bus.gnt); end
      total++; if (bus.fifo_write !== 1'b0) begin bad++; $display("FAIL reset_write got=%b exp=0", bus.fifo_write); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (stall !== 16'd0) begin bad++; $display("FAIL reset_stall got=%h exp=0", stall); end
      @(posedge clk); #1;
    end
    reset = 1'b1; tb_clr = 1'b0;
  endtask

  // req=1111 from reset: 4 words from 0, bubble, 1, bubble, 2, bubble, 3
  task automatic test_fairness();
    logic [3:0]  eg;
    logic [15:0] ed;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      eg = ((c % 5) == 0) ? 4'b0 : 4'(1 << ((c / 5) % 4));
      ed = {4'((c / 5) % 4), 12'((c % 5) - 1 + 4 * (c / 20))};
      total++; if (bus.gnt !== eg) begin bad++; $display("FAIL fair_gnt c=%0d got=%h exp=%h", c, bus.gnt, eg); end
      if (eg != 4'b0) begin
        total++; if (bus.fifo_data_in !== ed) begin bad++; $display("FAIL fair_data c=%0d got=%h exp=%h", c, bus.fifo_data_in, ed); end
      end
      if (c == 20) begin
        total++; if (cnt !== 16) begin bad++; $display("FAIL fair_count got=%0d exp=16", cnt); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full();
    logic wr_seen = 1'b0;
    logic gnt_seen = 1'b0;
    do_reset();
    bus.req = 4'b0100;
    for (int c = 0; c < 40; c++) begin @(negedge clk); @(posedge clk); #1; end
    @(negedge clk); // c=40: bubble, FIFO full
    total++; if (cnt !== 32) begin bad++; $display("FAIL full_count got=%0d exp=32", cnt); end
    total++; if (bus.fifo_full !== 1'b1) begin bad++; $display("FAIL full_flag got=%b exp=1", bus.fifo_full); end
    @(posedge clk); #1;
    for (int c = 41; c <= 50; c++) begin
      @(negedge clk);
      if (bus.fifo_write !== 1'b0) wr_seen = 1'b1;
      if (bus.gnt !== 4'b0) gnt_seen = 1'b1;
      @(posedge clk); #1;
    end
    @(negedge clk); // c=51
    total++; if (wr_seen !== 1'b0) begin bad++; $display("FAIL full_no_write got=%b exp=0", wr_seen); end
    total++; if (gnt_seen !== 1'b0) begin bad++; $display("FAIL full_no_gnt got=%b exp=0", gnt_seen); end
    total++; if (stall !== 16'd10) begin bad++; $display("FAIL full_stall got=%0d exp=10", stall); end
    total++; if (cnt !== 32) begin bad++; $display("FAIL full_stable got=%0d exp=32", cnt); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy got=%b exp=1", busy); end
    pop = 1'b1;
    @(posedge clk); #1;
    pop = 1'b0;
    @(negedge clk); // c=52: space freed, write resumes
    total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL full_resume_gnt got=%h exp=4", bus.gnt); end
    total++; if (bus.fifo_data_in !== 16'h2020) begin bad++; $display("FAIL full_resume_data got=%h exp=2020", bus.fifo_data_in); end
    total++; if (stall !== 16'd11) begin bad++; $display("FAIL full_stall2 got=%0d exp=11", stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_early_drop();
    do_reset();
    bus.req = 4'b0010;
    @(negedge clk); @(posedge clk); #1;   // c=0 pick 1
    @(negedge clk);                        // c=1
    total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL drop_gnt1 got=%h exp=2", bus.gnt); end
    total++; if (bus.fifo_data_in !== 16'h1000) begin bad++; $display("FAIL drop_data1 got=%h exp=1000", bus.fifo_data_in); end
    @(posedge clk); #1;
    @(negedge clk);                        // c=2
    total++; if (bus.fifo_data_in !== 16'h1001) begin bad++; $display("FAIL drop_data2 got=%h exp=1001", bus.fifo_data_in); end
    @(posedge clk); #1;
    bus.req = 4'b1000;
    @(negedge clk);                        // c=3 owner 1 dropped
    total++; if (bus.gnt !== 4'b0) begin bad++; $display("FAIL drop_gnt3 got=%h exp=0", bus.gnt); end
    @(posedge clk); #1;
    @(negedge clk);                        // c=4 idle
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_idle got=%b exp=0", busy); end
    @(posedge clk); #1;
    @(negedge clk);                        // c=5
    total++; if (owner !== 2'd3) begin bad++; $display("FAIL drop_owner got=%0d exp=3", owner); end
    total++; if (bus.gnt !== 4'b1000) begin bad++; $display("FAIL drop_gnt5 got=%h exp=8", bus.gnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.req = 4'b1111;
    for (int c = 0; c < 8; c++) begin @(negedge clk); @(posedge clk); #1; end
    reset = 1'b0;
    @(negedge clk);                        // c=8, reset cycle
    total++; if (bus.fifo_write !== 1'b0) begin bad++; $display("FAIL midrst_write got=%b exp=0", bus.fifo_write); end
    total++; if (cnt !== 6) begin bad++; $display("FAIL midrst_count got=%0d exp=6", cnt); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);                        // c=9
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_idle got=%b exp=0", busy); end
    total++; if (cnt !== 6) begin bad++; $display("FAIL midrst_count2 got=%0d exp=6", cnt); end
    @(posedge clk); #1;
    @(negedge clk);                        // c=10
    total++; if (owner !== 2'd0) begin bad++; $display("FAIL midrst_owner got=%0d exp=0", owner); end
    total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL midrst_gnt got=%h exp=1", bus.gnt); end
    total++; if (bus.fifo_data_in !== 16'h0004) begin bad++; $display("FAIL midrst_data got=%h exp=0004", bus.fifo_data_in); end
    @(posedge clk); #1;
  endtask

  task automatic test_burst1();
    logic [3:0] exp_g [6] = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001};
    do_reset();
    bus_b.req = 4'b0011;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++; if (bus_b.gnt !== exp_g[c]) begin bad++; $display("FAIL b1_gnt c=%0d got=%h exp=%h", c, bus_b.gnt, exp_g[c]); end
      if (c == 3) begin
        total++; if (bus_b.fifo_data_in !== 16'h1111) begin bad++; $display("FAIL b1_data got=%h exp=1111", bus_b.fifo_data_in); end
      end
      @(posedge clk); #1;
    end
    bus_b.req = '0;
  endtask

  task automatic test_random();
    int       exp_seq [4] = '{0, 0, 0, 0};
    int       errs = 0;
    logic [15:0] head;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus.fifo_write && bus.fifo_full) errs++;
      if (bus.gnt !== (bus.fifo_write ? 4'(1 << owner) : 4'b0)) errs++;
      if (bus.fifo_data_in !== bus.req_data[owner]) errs++;
      if (pop && cnt > 0) begin
        head = q[0];
        if (head[11:0] !== 12'(exp_seq[head[15:12]])) errs++;
        exp_seq[head[15:12]]++;
      end
      @(posedge clk); #1;
      bus.req = 4'($urandom);
      pop = ($urandom_range(0, 9) < 4);
    end
    bus.req = '0; pop = 1'b0;
    total++; if (errs !== 0) begin bad++; $display("FAIL random_scoreboard got=%0d errors exp=0", errs); end
    total++; if (exp_seq[0] + exp_seq[1] + exp_seq[2] + exp_seq[3] < 100) begin
      bad++; $display("FAIL random_traffic got=%0d pops exp>=100", exp_seq[0] + exp_seq[1] + exp_seq[2] + exp_seq[3]);
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_full();
    test_early_drop();
    test_reset_mid_burst();
    test_burst1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
